sdram_ctrl_seq: RTL and testbench

Command sequencer for the i2d SoC SDRAM controller. It runs the JEDEC power-up init, then serves single-word read/write requests from the bus side. It interleaves auto-refresh when the refresh-timer block raises ref_req, and drives refreshing back to that block. All SDRAM command/address/data pins are registered here.

---
 rtl/sdram_ctrl_seq_pkg.sv | 39 +++
 rtl/sdram_ctrl_seq_if.sv | 13 +
 rtl/sdram_ctrl_timer.sv | 30 +++
 rtl/sdram_ctrl_seq.sv | 188 ++++++++++++++++++
 tb/tb_sdram_ctrl_seq.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_ctrl_seq_pkg.sv
// rtl/sdram_ctrl_seq_pkg.sv - shared command encodings, FSM states and address slices for sdram_ctrl_seq
// The {cs_n,ras_n,cas_n,we_n} codes and the {bank,row,col} word-address split live here.
package sdram_ctrl_seq_pkg;

    localparam logic [3:0] CMD_INH = 4'b1111;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;

    localparam int BA_HI  = 23;
    localparam int BA_LO  = 22;
    localparam int ROW_HI = 21;
    localparam int ROW_LO = 9;
    localparam int COL_HI = 8;
    localparam int COL_LO = 0;

    typedef enum logic [3:0] {
        S_INIT_WAIT,
        S_INIT_PRE,
        S_INIT_REF1,
        S_INIT_REF2,
        S_INIT_MRS,
        S_IDLE,
        S_REFRESH,
        S_ACT,
        S_WR,
        S_RD
    } state_e;

    // Column address with A10 set so every access auto-precharges its bank.
    function automatic logic [12:0] col_ap(input logic [8:0] col);
        return {2'b00, 1'b1, 1'b0, col};
    endfunction

endpackage

// File: rtl/sdram_ctrl_seq_if.sv
// rtl/sdram_ctrl_seq_if.sv - single-word request/response bus between the SoC side and sdram_ctrl_seq
interface sdram_ctrl_seq_if;
    logic        req;
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;
    logic        rvalid;

    modport master (output req, we, addr, wdata, input ack, rdata, rvalid);
    modport slave  (input req, we, addr, wdata, output ack, rdata, rvalid);
endinterface

// File: rtl/sdram_ctrl_timer.sv
// rtl/sdram_ctrl_timer.sv - 16-bit loadable down-counter with zero flag for SDRAM wait states
module sdram_ctrl_timer #(
    parameter logic [15:0] RST_VAL = 16'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] cnt,
    output logic        zero
);
    logic [15:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= RST_VAL;
        else        cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == 16'd0);
endmodule

// File: rtl/sdram_ctrl_seq.sv
// rtl/sdram_ctrl_seq.sv - SDRAM command sequencer: power-up init, auto-refresh, single-word read/write
// Optional SDRAM_CTRL_SEQ_STAT_EN adds ref_cnt, a saturating count of post-init REF commands.
module sdram_ctrl_seq
    import sdram_ctrl_seq_pkg::*;
#(
    parameter int unsigned T_INIT  = 20000,
    parameter int unsigned T_RP    = 2,
    parameter int unsigned T_RFC   = 7,
    parameter int unsigned T_MRD   = 2,
    parameter int unsigned T_RCD   = 2,
    parameter int unsigned T_WR    = 2,
    parameter int unsigned CAS_LAT = 2,
    parameter logic [12:0] MODE    = 13'h020
) (
    input  logic              clk,
    input  logic              rst,
    sdram_ctrl_seq_if.slave   bus,
    input  logic              ref_req,
    output logic              refreshing,
    output logic              init_done,
    output logic              sd_cke,
    output logic              sd_cs_n,
    output logic              sd_ras_n,
    output logic              sd_cas_n,
    output logic              sd_we_n,
    output logic [1:0]        sd_ba,
    output logic [12:0]       sd_a,
    output logic [1:0]        sd_dqm,
    output logic [15:0]       sd_dq_o,
    output logic              sd_dq_oe,
`ifdef SDRAM_CTRL_SEQ_STAT_EN
    output logic [15:0]       ref_cnt,
`endif
    input  logic [15:0]       sd_dq_i
);
    state_e      state_d, state_q;
    logic [3:0]  cmd_d, cmd_q;
    logic [1:0]  ba_d, ba_q, dqm_d, dqm_q;
    logic [12:0] a_d, a_q;
    logic [15:0] dq_o_d, dq_o_q, rdata_d, rdata_q;
    logic        dq_oe_d, dq_oe_q, ack_d, ack_q, rvalid_d, rvalid_q;
    logic        init_done_d, init_done_q, refreshing_d, refreshing_q, cke_q;
    logic        tmr_load, tmr_zero;
    logic [15:0] tmr_val, tmr_cnt;

    sdram_ctrl_timer #(.RST_VAL(16'(T_INIT))) u_timer (
        .clk      (clk),
        .rst_n    (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    // Every command is issued on the edge its wait expires, so the next command lands T+1 cycles later.
    always_comb begin
        state_d      = state_q;
        cmd_d        = CMD_NOP;
        ba_d         = ba_q;
        a_d          = a_q;
        dqm_d        = dqm_q;
        dq_o_d       = 16'h0000;
        dq_oe_d      = 1'b0;
        ack_d        = 1'b0;
        rvalid_d     = 1'b0;
        rdata_d      = rdata_q;
        init_done_d  = init_done_q;
        refreshing_d = refreshing_q;
        tmr_load     = 1'b0;
        tmr_val      = 16'h0000;
        case (state_q)
            S_INIT_WAIT: if (tmr_zero) begin
                cmd_d = CMD_PRE; a_d = 13'h0400;
                tmr_load = 1'b1; tmr_val = 16'(T_RP); state_d = S_INIT_PRE;
            end
            S_INIT_PRE: if (tmr_zero) begin
                cmd_d = CMD_REF;
                tmr_load = 1'b1; tmr_val = 16'(T_RFC); state_d = S_INIT_REF1;
            end
            S_INIT_REF1: if (tmr_zero) begin
                cmd_d = CMD_REF;
                tmr_load = 1'b1; tmr_val = 16'(T_RFC); state_d = S_INIT_REF2;
            end
            S_INIT_REF2: if (tmr_zero) begin
                cmd_d = CMD_LMR; a_d = MODE; ba_d = 2'b00;
                tmr_load = 1'b1; tmr_val = 16'(T_MRD); state_d = S_INIT_MRS;
            end
            S_INIT_MRS: if (tmr_zero) begin
                init_done_d = 1'b1; dqm_d = 2'b00; state_d = S_IDLE;
            end
            S_IDLE: if (ref_req) begin
                cmd_d = CMD_REF; refreshing_d = 1'b1;
                tmr_load = 1'b1; tmr_val = 16'(T_RFC - 1); state_d = S_REFRESH;
            end else if (bus.req) begin
                cmd_d = CMD_ACT;
                ba_d  = bus.addr[BA_HI:BA_LO];
                a_d   = bus.addr[ROW_HI:ROW_LO];
                tmr_load = 1'b1; tmr_val = 16'(T_RCD - 1); state_d = S_ACT;
            end
            S_REFRESH: if (tmr_zero) begin
                refreshing_d = 1'b0; state_d = S_IDLE;
            end
            S_ACT: if (tmr_zero) begin
                ack_d = 1'b1;
                a_d   = col_ap(bus.addr[COL_HI:COL_LO]);
                tmr_load = 1'b1;
                if (bus.we) begin
                    cmd_d = CMD_WR; dq_oe_d = 1'b1; dq_o_d = bus.wdata;
                    tmr_val = 16'(T_WR + T_RP - 1); state_d = S_WR;
                end else begin
                    cmd_d = CMD_RD;
                    tmr_val = 16'(CAS_LAT + T_RP); state_d = S_RD;
                end
            end
            S_WR: if (tmr_zero) state_d = S_IDLE;
            S_RD: begin
                // CAS_LAT cycles after RD the timer sits at T_RP: capture the pad then.
                if (tmr_cnt == 16'(T_RP)) begin
                    rvalid_d = 1'b1; rdata_d = sd_dq_i;
                end
                if (tmr_zero) state_d = S_IDLE;
            end
            default: state_d = S_INIT_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_INIT_WAIT;
            cmd_q        <= CMD_INH;
            cke_q        <= 1'b0;
            ba_q         <= 2'b00;
            a_q          <= 13'h0000;
            dqm_q        <= 2'b11;
            dq_o_q       <= 16'h0000;
            dq_oe_q      <= 1'b0;
            ack_q        <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= 16'h0000;
            init_done_q  <= 1'b0;
            refreshing_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cke_q        <= 1'b1;
            ba_q         <= ba_d;
            a_q          <= a_d;
            dqm_q        <= dqm_d;
            dq_o_q       <= dq_o_d;
            dq_oe_q      <= dq_oe_d;
            ack_q        <= ack_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            init_done_q  <= init_done_d;
            refreshing_q <= refreshing_d;
        end
    end

`ifdef SDRAM_CTRL_SEQ_STAT_EN
    logic [15:0] ref_cnt_d, ref_cnt_q;

    // Init REFs all go out before init_done rises, so only runtime refreshes are counted.
    always_comb begin
        ref_cnt_d = ref_cnt_q;
        if (cmd_q == CMD_REF && init_done_q && ref_cnt_q != 16'hFFFF) ref_cnt_d = ref_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ref_cnt_q <= 16'h0000;
        else      ref_cnt_q <= ref_cnt_d;
    end

    assign ref_cnt = ref_cnt_q;
`endif

    assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd_q;
    assign sd_cke     = cke_q;
    assign sd_ba      = ba_q;
    assign sd_a       = a_q;
    assign sd_dqm     = dqm_q;
    assign sd_dq_o    = dq_o_q;
    assign sd_dq_oe   = dq_oe_q;
    assign bus.ack    = ack_q;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign refreshing = refreshing_q;
    assign init_done  = init_done_q;
endmodule

// File: tb/tb_sdram_ctrl_seq.sv
// tb/tb_sdram_ctrl_seq.sv - directed self-checking bench for sdram_ctrl_seq (T_INIT=8)
module tb_sdram_ctrl_seq;
    localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000;
    localparam logic [3:0] ACT = 4'b0011, RD  = 4'b0101, WR  = 4'b0100, INH = 4'b1111;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdq;
        logic [1:0]  ba;
        logic [12:0] row;
        logic [8:0]  col;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ref_req;
    logic [15:0] sd_dq_i;
    wire         refreshing, init_done, sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_dq_oe;
    wire  [1:0]  sd_ba, sd_dqm;
    wire  [12:0] sd_a;
    wire  [15:0] sd_dq_o;
`ifdef SDRAM_CTRL_SEQ_STAT_EN
    wire  [15:0] ref_cnt;
`endif
    wire  [3:0]  cmd = {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n};

    int checks = 0;
    int errors = 0;
    acc_t vecs [6];

    sdram_ctrl_seq_if bus ();

    always #5 clk = ~clk;

    sdram_ctrl_seq #(.T_INIT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ref_req    (ref_req),
        .refreshing (refreshing),
        .init_done  (init_done),
        .sd_cke     (sd_cke),
        .sd_cs_n    (sd_cs_n),
        .sd_ras_n   (sd_ras_n),
        .sd_cas_n   (sd_cas_n),
        .sd_we_n    (sd_we_n),
        .sd_ba      (sd_ba),
        .sd_a       (sd_a),
        .sd_dqm     (sd_dqm),
        .sd_dq_o    (sd_dq_o),
        .sd_dq_oe   (sd_dq_oe),
`ifdef SDRAM_CTRL_SEQ_STAT_EN
        .ref_cnt    (ref_cnt),
`endif
        .sd_dq_i    (sd_dq_i)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_cke", sd_cke, 0);
        chk("rst_cmd", cmd, INH);
        chk("rst_ba", sd_ba, 0);
        chk("rst_a", sd_a, 0);
        chk("rst_dqm", sd_dqm, 2'b11);
        chk("rst_dq_oe", sd_dq_oe, 0);
        chk("rst_dq_o", sd_dq_o, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_refreshing", refreshing, 0);
    endtask

    // Entered in the cycle reset is released (cycle 0); returns in cycle 31, the first IDLE cycle.
    task automatic init_seq();
        logic [3:0] e;
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            e = (c == 9) ? PRE : (c == 12 || c == 20) ? REF : (c == 28) ? LMR : NOP;
            chk("init_cke", sd_cke, 1);
            chk("init_cmd", cmd, e);
            if (c == 9) chk("init_pre_a10", sd_a[10], 1);
            if (c == 28) begin
                chk("init_lmr_a", sd_a, 13'h020);
                chk("init_lmr_ba", sd_ba, 0);
            end
            if (c >= 30) chk("init_dqm", sd_dqm, (c == 31) ? 2'b00 : 2'b11);
            chk("init_done", init_done, c == 31);
            chk("init_ack", bus.ack, 0);
            chk("init_refreshing", refreshing, 0);
        end
    endtask

    // Called in an IDLE cycle; returns in the next IDLE cycle (WR+4 or RD+5).
    task automatic do_access(input acc_t v);
        int last;
        logic [3:0] e;
        bus.req = 1'b1; bus.we = v.we; bus.addr = v.addr; bus.wdata = v.wdata;
        last = v.we ? 7 : 8;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            e = (k == 1) ? ACT : (k == 3) ? (v.we ? WR : RD) : NOP;
            chk("acc_cmd", cmd, e);
            if (k == 1) begin
                chk("acc_act_ba", sd_ba, v.ba);
                chk("acc_act_row", sd_a, v.row);
            end
            if (k == 3) begin
                chk("acc_rw_ba", sd_ba, v.ba);
                chk("acc_rw_a10", sd_a[10], 1);
                chk("acc_rw_col", sd_a[8:0], v.col);
                bus.req = 1'b0;
            end
            chk("acc_ack", bus.ack, k == 3);
            chk("acc_dq_oe", sd_dq_oe, v.we && k == 3);
            if (v.we && k == 3) chk("acc_dq_o", sd_dq_o, v.wdata);
            chk("acc_rvalid", bus.rvalid, !v.we && k == 6);
            if (!v.we && k == 6) chk("acc_rdata", bus.rdata, v.rdq);
            if (!v.we) sd_dq_i = (k == 5) ? v.rdq : ~v.rdq;
        end
        sd_dq_i = 16'h0000;
    endtask

    initial begin
        int acks;
        logic [3:0] e;
        vecs[0] = '{1'b1, 24'h412345, 16'hBEEF, 16'h0000, 2'd1, 13'h0091, 9'h145};
        vecs[1] = '{1'b0, 24'h412345, 16'h0000, 16'hCAFE, 2'd1, 13'h0091, 9'h145};
        vecs[2] = '{1'b1, 24'hFFFFFF, 16'h0001, 16'h0000, 2'd3, 13'h1FFF, 9'h1FF};
        vecs[3] = '{1'b0, 24'h000000, 16'h0000, 16'hA5A5, 2'd0, 13'h0000, 9'h000};
        vecs[4] = '{1'b1, 24'h800200, 16'h5A5A, 16'h0000, 2'd2, 13'h0001, 9'h000};
        vecs[5] = '{1'b0, 24'h7FC1FF, 16'h0000, 16'h1357, 2'd1, 13'h1FE0, 9'h1FF};

        rst = 1'b0; ref_req = 1'b0; sd_dq_i = 16'h0000;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 24'h0; bus.wdata = 16'h0;
        repeat (2) @(negedge clk);
        chk_reset_vals();

        // ref_req held through init must be ignored, then served first thing in IDLE.
        ref_req = 1'b1;
        rst = 1'b1;
        init_seq();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("ref_cmd", cmd, (k == 1) ? REF : NOP);
            chk("ref_refreshing", refreshing, k <= 7);
            if (k == 1) ref_req = 1'b0;
        end

        for (int i = 0; i < 6; i++) do_access(vecs[i]);

        // Simultaneous ref_req and req: refresh wins, write follows.
        ref_req = 1'b1; bus.req = 1'b1; bus.we = 1'b1; bus.addr = 24'h800200; bus.wdata = 16'h1111;
        acks = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            e = (k == 1) ? REF : (k == 9) ? ACT : (k == 11) ? WR : NOP;
            chk("prio_cmd", cmd, e);
            chk("prio_refreshing", refreshing, k <= 7);
            if (k == 1) ref_req = 1'b0;
            if (bus.ack) begin
                acks++;
                bus.req = 1'b0;
            end
        end
        chk("prio_acks", acks, 1);

        // ref_req rising in the ACT cycle waits for the read to finish.
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 24'h412345;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            e = (k == 1) ? ACT : (k == 3) ? RD : (k == 9) ? REF : NOP;
            chk("midrd_cmd", cmd, e);
            chk("midrd_ack", bus.ack, k == 3);
            chk("midrd_rvalid", bus.rvalid, k == 6);
            if (k == 6) chk("midrd_rdata", bus.rdata, 16'h2468);
            chk("midrd_refreshing", refreshing, k >= 9 && k <= 15);
            if (k == 1) ref_req = 1'b1;
            if (k == 3) bus.req = 1'b0;
            if (k == 9) ref_req = 1'b0;
            sd_dq_i = (k == 5) ? 16'h2468 : 16'h0000;
        end
`ifdef SDRAM_CTRL_SEQ_STAT_EN
        chk("ref_cnt", ref_cnt, 3);
`endif

        // Reset in the ACT-to-WR gap: asynchronous clear, no ack, full init replay.
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 24'hFFFFFF; bus.wdata = 16'h0001;
        @(negedge clk);
        chk("rstw_act", cmd, ACT);
        @(negedge clk);
        chk("rstw_gap", cmd, NOP);
        rst = 1'b0;
        #1;
        chk_reset_vals();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstw_ack", bus.ack, 0);
            chk("rstw_cmd", cmd, INH);
        end
        rst = 1'b1;
        init_seq();
`ifdef SDRAM_CTRL_SEQ_STAT_EN
        chk("ref_cnt_rst", ref_cnt, 0);
`endif
        do_access(vecs[2]);
        do_access(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
